// File: rtl/sort_ram_2r1w.sv
// Sorter storage: one write port, two registered read ports, and a sequential
// clear engine that sweeps CLEAR_VALUE through the array after reset or on request.
module sort_ram_2r1w #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  rvalid_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rvalid_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    access;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            // ptr naturally wraps to 0 on the last clear write
            if (state_q == S_CLEAR) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy = 1'b1;
                if (&ptr_q) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                end else begin
                    access = 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[ptr_q] <= CLEAR_VALUE;
        end else if (access && we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-first: a same-edge write to the read address bypasses the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a  <= '0;
            rvalid_a <= 1'b0;
            rdata_b  <= '0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= access && re_a;
            rvalid_b <= access && re_b;
            if (access && re_a) begin
                rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
            end
            if (access && re_b) begin
                rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
            end
        end
    end

endmodule
